gray_seq_gen: RTL and testbench
===============================

# gray_seq_gen

Registered Gray-code sequence generator with a valid/ready output handshake, sitting directly upstream of the 4-bit Gray-to-binary decoder. Keeps an internal binary count, presents its Gray encoding one code per transfer, and raises a one-cycle wrap flag on counter roll-over. The downstream decoder consumes `gray` combinationally and drives `out_ready`.

## Interface
- `W`, default 4: code width in bits. The downstream decoder requires 4; other values are for reuse only.
- `clk`  in  1  single clock, all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `en`  in  1  request to produce codes; low = pause after the pending code is accepted
- `load`  in  1  load strobe; highest priority after reset
- `load_bin`  in  W  binary start value, used when `load`=1
- `dir`  in  1  0 = count up, 1 = count down; present only with `GRAY_SEQ_UPDOWN_EN`
- `gray`  out  W  registered Gray code, equal to `cnt ^ (cnt >> 1)`
- `out_valid`  out  1  `gray` holds a code not yet accepted
- `out_ready`  in  1  consumer accepts `gray` this cycle
- `wrap`  out  1  one-cycle pulse, registered

## Operation
- State:
  - `cnt` (W-bit binary).
  - Output registers: `gray`, `out_valid`, `wrap`.
- Transfer: `xfer = out_valid & out_ready`.
- Reset (`rst_n`=0 at a rising edge): `cnt`=0, `gray`=0, `out_valid`=0, `wrap`=0. Overrides `load`, `en` and `out_ready`.
- Priority per cycle is reset > load > transfer/advance.
- Load:
  - `cnt`=`load_bin` and `gray`=Gray(`load_bin`).
  - `out_valid`=0 and `wrap`=0.
  - A pending unaccepted code is discarded. This is the only case where `out_valid` falls without a transfer.
- Valid rules:
  - `out_valid` rises the cycle after `en`=1 is seen with `out_valid`=0.
  - Once high, `out_valid` stays high until `xfer`. The bench asserts this.
  - On `xfer` with `en`=1, `out_valid` stays high.
  - On `xfer` with `en`=0, `out_valid` falls.
- Advance on `xfer`:
  - `cnt` goes to `cnt+1` (up) or `cnt-1` (down), modulo 2^W.
  - `gray` is updated to Gray(new `cnt`).
- Wrap:
  - Up: `wrap`=1 on the cycle after an `xfer` at `cnt`=2^W-1 (`gray`=1000 for W=4).
  - Down: `wrap`=1 on the cycle after an `xfer` at `cnt`=0.
  - Otherwise `wrap`=0.
- `en` low with `out_valid`=0: all state holds, and `gray` keeps its last value.
- `dir` is sampled only on `xfer`. Changing `dir` mid-stream reverses from the current code with no skipped code.
- Every successive pair of accepted codes differs in exactly one bit, including across wrap.

## Timing
- Latency from `en` rising (with `out_valid`=0) to `out_valid`=1 is 1 cycle. The first code presented is the current `cnt`, i.e. 0000 after reset.
- Throughput is one code per cycle while `en`=1 and `out_ready`=1.
- `gray`, `out_valid` and `wrap` are flop outputs. There is no combinational path from any input to any output.
- Simultaneous `load` and `xfer`: load wins, and the transfer is treated as not having happened (no advance, no wrap).
- Reset asserted mid-stream: outputs return to reset values at that edge regardless of the handshake.

## Configuration
- `GRAY_SEQ_UPDOWN_EN` defined:
  - The `dir` port exists.
  - Down-counting and down-wrap detection are compiled in.
- Not defined:
  - No `dir` port.
  - Always counts up, and only up-wrap is detected.
  - Logic is reduced accordingly.

## Structure
- Shared package `gray_pkg` holds:
  - `GRAY_W` = 4.
  - Typedef `gray_t` = `logic [GRAY_W-1:0]`.
  - Function `bin_to_gray`.
  - Constant `GRAY_TERM_UP` = 4'b1000.
- One sub-module, `bin2gray` (parameter W): purely combinational, `g = b ^ (b >> 1)`. It is instantiated once on the next-count path feeding the `gray` register.

## Test plan
- Reset, hold `en`=0 for 3 cycles, then `en`=1 with `out_ready`=1 -> `out_valid` rises 1 cycle later. `gray` sequence is 0000, 0001, 0011, 0010, 0110, …, 1000, 0000, and `wrap`=1 on the cycle `gray` returns to 0000.
- `en`=1 with `out_ready`=0 for 5 cycles, then 1 -> `gray` holds 0000 with `out_valid`=1 throughout the stall, then advances to 0001.
- `load`=1 with `load_bin`=4'd12 while `out_valid`=1 and `out_ready`=1 -> next cycle `gray`=1010, `out_valid`=0, `wrap`=0, and no advance.
- With the macro: at `cnt`=1 (`gray`=0001), set `dir`=1 -> transfers give 0000, then `wrap`=1 with `gray`=1000 (cnt 15), then 1001.
- Drop `rst_n` mid-stream at `gray`=0110 -> next edge `gray`=0000, `out_valid`=0, `wrap`=0.
- Random `en` and `out_ready` over 1000 cycles -> each accepted code differs from the previous accepted code in exactly one bit, and `out_valid` never falls without `xfer` or `load`.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared Gray-code definitions for the sequence generator and its 4-bit decoder.
package gray_pkg;

    localparam int GRAY_W = 4;

    typedef logic [GRAY_W-1:0] gray_t;

    // Gray code of the last up-count value; seeing it on a transfer means roll-over.
    localparam gray_t GRAY_TERM_UP = 4'b1000;

    function automatic gray_t bin_to_gray(input gray_t b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/bin2gray.sv
// Combinational binary-to-Gray converter: g = b ^ (b >> 1).
module bin2gray #(
    parameter int W = 4
) (
    input  logic [W-1:0] b_i,
    output logic [W-1:0] g_o
);

    assign g_o = b_i ^ (b_i >> 1);

endmodule

// File: rtl/gray_seq_gen.sv
// Registered Gray-code sequence generator with valid/ready output and wrap pulse.
// Defining GRAY_SEQ_UPDOWN_EN adds the dir_i port and down-counting.
module gray_seq_gen
    import gray_pkg::*;
#(
    parameter int W = GRAY_W
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         en_i,
    input  logic         load_i,
    input  logic [W-1:0] load_bin_i,
`ifdef GRAY_SEQ_UPDOWN_EN
    input  logic         dir_i,
`endif
    output logic [W-1:0] gray_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         wrap_o
);

    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] gray_q, gray_d;
    logic         valid_q, valid_d;
    logic         wrap_q, wrap_d;
    logic         xfer;
    logic         at_top;
    logic [W-1:0] cnt_step;
    logic         step_wraps;

    assign xfer = valid_q & out_ready_i;

    generate
        if (W == GRAY_W) begin : g_term_fixed
            assign at_top = (gray_q == GRAY_TERM_UP);
        end else begin : g_term_generic
            assign at_top = &cnt_q;
        end
    endgenerate

`ifdef GRAY_SEQ_UPDOWN_EN
    assign cnt_step   = dir_i ? (cnt_q - W'(1)) : (cnt_q + W'(1));
    assign step_wraps = dir_i ? (cnt_q == '0) : at_top;
`else
    assign cnt_step   = cnt_q + W'(1);
    assign step_wraps = at_top;
`endif

    // Load discards any pending code; otherwise advance only on an accepted transfer.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        if (load_i) begin
            cnt_d   = load_bin_i;
            valid_d = 1'b0;
        end else if (xfer) begin
            cnt_d   = cnt_step;
            wrap_d  = step_wraps;
            valid_d = en_i;
        end else if (!valid_q && en_i) begin
            valid_d = 1'b1;
        end
    end

    // The gray register always tracks the encoding of the next count.
    bin2gray #(.W(W)) u_bin2gray (
        .b_i (cnt_d),
        .g_o (gray_d)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_q   <= '0;
            gray_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            gray_q  <= gray_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
        end
    end

    assign gray_o      = gray_q;
    assign out_valid_o = valid_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_gray_seq_gen.sv
// Directed and random-handshake bench for gray_seq_gen (up/down path when GRAY_SEQ_UPDOWN_EN is defined).
module tb_gray_seq_gen;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       load;
    logic [3:0] load_bin;
    logic       dir;
    logic [3:0] gray;
    logic       out_valid;
    logic       out_ready;
    logic       wrap;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    gray_seq_gen #(.W(4)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .en_i        (en),
        .load_i      (load),
        .load_bin_i  (load_bin),
`ifdef GRAY_SEQ_UPDOWN_EN
        .dir_i       (dir),
`endif
        .gray_o      (gray),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .wrap_o      (wrap)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] g, input logic v, input logic w);
        chk({tag, ".gray"}, gray, g);
        chk({tag, ".valid"}, {3'b0, out_valid}, {3'b0, v});
        chk({tag, ".wrap"}, {3'b0, wrap}, {3'b0, w});
        $display("step %-10s gray=%b valid=%b wrap=%b", tag, gray, out_valid, wrap);
    endtask

    logic [3:0] gseq [0:15];
    logic [3:0] g_before, prev_acc;
    logic       v_before, x_before, have_prev;

    initial begin
        gseq[0]  = 4'b0000; gseq[1]  = 4'b0001; gseq[2]  = 4'b0011; gseq[3]  = 4'b0010;
        gseq[4]  = 4'b0110; gseq[5]  = 4'b0111; gseq[6]  = 4'b0101; gseq[7]  = 4'b0100;
        gseq[8]  = 4'b1100; gseq[9]  = 4'b1101; gseq[10] = 4'b1111; gseq[11] = 4'b1110;
        gseq[12] = 4'b1010; gseq[13] = 4'b1011; gseq[14] = 4'b1001; gseq[15] = 4'b1000;

        rst_n = 1'b0; en = 1'b1; load = 1'b1; load_bin = 4'd9; dir = 1'b0; out_ready = 1'b1;
        tick();
        chk_out("reset", 4'b0000, 1'b0, 1'b0);

        // Idle with en low: nothing moves
        rst_n = 1'b1; en = 1'b0; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out("idle", 4'b0000, 1'b0, 1'b0);
        end

        // Full up sequence at one code per cycle
        en = 1'b1;
        tick();
        chk_out("first", 4'b0000, 1'b1, 1'b0);
        for (int i = 1; i < 16; i++) begin
            tick();
            chk_out("seq", gseq[i], 1'b1, 1'b0);
        end
        tick();
        chk_out("wrap", 4'b0000, 1'b1, 1'b1);

        // Stall at 0000 for 5 cycles
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("stall", 4'b0000, 1'b1, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        chk_out("resume", 4'b0001, 1'b1, 1'b0);

        // Load while a transfer is offered: load wins, no advance
        load = 1'b1; load_bin = 4'd12;
        tick();
        chk_out("load", 4'b1010, 1'b0, 1'b0);
        load = 1'b0;
        tick();
        chk_out("load_v", 4'b1010, 1'b1, 1'b0);
        tick();
        chk_out("load_adv", 4'b1011, 1'b1, 1'b0);

        // Transfer with en low drops valid and then everything holds
        en = 1'b0;
        tick();
        chk_out("en_off", 4'b1001, 1'b0, 1'b0);
        tick();
        chk_out("en_hold", 4'b1001, 1'b0, 1'b0);

        // Reset mid-stream at 0110
        load = 1'b1; load_bin = 4'd4; en = 1'b1;
        tick();
        load = 1'b0;
        tick();
        chk_out("pre_rst", 4'b0110, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk_out("mid_rst", 4'b0000, 1'b0, 1'b0);
        rst_n = 1'b1;

`ifdef GRAY_SEQ_UPDOWN_EN
        // Reverse from cnt=1 through the down wrap
        load = 1'b1; load_bin = 4'd1;
        tick();
        load = 1'b0; dir = 1'b1;
        tick();
        chk_out("dn_first", 4'b0001, 1'b1, 1'b0);
        tick();
        chk_out("dn_0", 4'b0000, 1'b1, 1'b0);
        tick();
        chk_out("dn_wrap", 4'b1000, 1'b1, 1'b1);
        tick();
        chk_out("dn_14", 4'b1001, 1'b1, 1'b0);
        dir = 1'b0;
        tick();
        chk_out("up_again", 4'b1000, 1'b1, 1'b0);
        tick();
        chk_out("up_wrap", 4'b0000, 1'b1, 1'b1);
`endif

        // Random handshake: one-bit steps between accepted codes, valid never drops unasked
        dir = 1'b0; load = 1'b0;
        have_prev = 1'b0;
        prev_acc = 4'b0000;
        for (int i = 0; i < 1000; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 1));
            g_before = gray;
            v_before = out_valid;
            x_before = out_valid & out_ready;
            tick();
            if (x_before) begin
                if (have_prev)
                    chk("rnd_onebit", 4'($countones(prev_acc ^ g_before)), 4'd1);
                prev_acc = g_before;
                have_prev = 1'b1;
                chk("rnd_wrap", {3'b0, wrap}, {3'b0, (g_before == 4'b1000)});
            end else if (v_before) begin
                chk("rnd_hold_v", {3'b0, out_valid}, 4'd1);
                chk("rnd_hold_g", gray, g_before);
            end
        end
        $display("random phase done, last accepted gray=%b", prev_acc);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
